// File: rtl/router_pkg.sv
// router_pkg: shared state encoding, default sizes and timeout width helper for the 1xN router FSM
package router_pkg;
  localparam int DEF_NUM_CH = 3;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_WAIT_TIMEOUT = 32;
  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    WAIT_TILL_EMPTY    = 4'd1,
    LOAD_FIRST_DATA    = 4'd2,
    LOAD_DATA          = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    LOAD_PARITY        = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;
  function automatic int to_width(input int t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/router_wait_timer.sv
// router_wait_timer: up-counter with clear and enable that saturates at a terminal value
module router_wait_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term_val,
  output logic         term
);
  logic [W-1:0] count;
  assign term = count == term_val;
  // count while enabled, hold at the terminal value, restart on clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) count <= '0;
    else if (clr) count <= '0;
    else if (en && !term) count <= count + 1'b1;
  end
endmodule

// File: rtl/router_fsm_nch.sv
// router_fsm_nch: 1xN router control FSM with invalid-address drop and wait timeout
module router_fsm_nch import router_pkg::*; #(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT,
  parameter int TO_W         = to_width(DEF_WAIT_TIMEOUT)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              packet_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic              parity_done,
  input  logic              low_packet_valid,
  output logic              write_enb_reg,
  output logic              detect_add,
  output logic              ld_state,
  output logic              laf_state,
  output logic              lfd_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              busy,
  output logic              drop_state,
  output logic              pkt_drop,
  output logic [NUM_CH-1:0] sel,
  output logic [3:0]        present_state
);
  localparam int NA = 2 ** ADDR_W;
  state_t st, nx;
  logic [ADDR_W-1:0] addr_q;
  logic [NA-1:0] emp_x, sr_x;
  logic bad_addr, term, timeout, idle;
  assign emp_x    = NA'(fifo_empty);
  assign sr_x     = NA'(soft_reset);
  assign bad_addr = {1'b0, data_in} >= (ADDR_W + 1)'(NUM_CH);
  assign timeout  = (WAIT_TIMEOUT != 0) && term;
  assign idle     = st == DECODE_ADDRESS || st == DROP_PACKET;
  router_wait_timer #(.W(TO_W)) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (st != WAIT_TILL_EMPTY),
    .en       (1'b1),
    .term_val (TO_W'(WAIT_TIMEOUT - 1)),
    .term     (term)
  );
  // next-state logic; a soft reset of the selected channel overrides every transition
  always_comb begin
    nx = st;
    case (st)
      DECODE_ADDRESS:     if (packet_valid) nx = bad_addr ? DROP_PACKET : emp_x[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:    nx = emp_x[addr_q] ? LOAD_FIRST_DATA : timeout ? DROP_PACKET : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:    nx = LOAD_DATA;
      LOAD_DATA:          nx = fifo_full ? FIFO_FULL_STATE : !packet_valid ? LOAD_PARITY : LOAD_DATA;
      FIFO_FULL_STATE:    nx = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    nx = parity_done ? DECODE_ADDRESS : low_packet_valid ? LOAD_PARITY : LOAD_DATA;
      LOAD_PARITY:        nx = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: nx = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      DROP_PACKET:        nx = packet_valid ? DROP_PACKET : DECODE_ADDRESS;
      default:            nx = DECODE_ADDRESS;
    endcase
    if (!idle && sr_x[addr_q]) nx = DECODE_ADDRESS;
  end
  // state register, header address latch and drop-entry pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st       <= DECODE_ADDRESS;
      addr_q   <= '0;
      pkt_drop <= 1'b0;
    end else begin
      st       <= nx;
      pkt_drop <= nx == DROP_PACKET && st != DROP_PACKET;
      if (st == DECODE_ADDRESS && packet_valid) addr_q <= data_in;
    end
  end
  assign write_enb_reg = st == LOAD_DATA || st == LOAD_PARITY || st == LOAD_AFTER_FULL;
  assign detect_add    = st == DECODE_ADDRESS;
  assign ld_state      = st == LOAD_DATA;
  assign laf_state     = st == LOAD_AFTER_FULL;
  assign lfd_state     = st == LOAD_FIRST_DATA;
  assign full_state    = st == FIFO_FULL_STATE;
  assign rst_int_reg   = st == CHECK_PARITY_ERROR;
  assign drop_state    = st == DROP_PACKET;
  assign busy          = !(idle || st == LOAD_DATA);
  assign sel           = idle ? '0 : NUM_CH'(1) << addr_q;
  assign present_state = st;
endmodule

// File: tb/tb_router_fsm_nch.sv
// tb_router_fsm_nch: directed and random stimulus for 3- and 8-channel routers against a behavioural model
module tb_router_fsm_nch;
  localparam int M_DA = 0, M_WT = 1, M_LFD = 2, M_LD = 3, M_FFS = 4, M_LAF = 5, M_LP = 6, M_CPE = 7, M_DRP = 8;
  localparam int TO = 32;
  logic clk, resetn, pv, full, pd, lpv;
  logic [2:0] din;
  logic [7:0] emp, sr;
  logic a_we, a_da, a_ld, a_laf, a_lfd, a_full, a_rst, a_busy, a_drop, a_pd;
  logic b_we, b_da, b_ld, b_laf, b_lfd, b_full, b_rst, b_busy, b_drop, b_pd;
  logic [2:0] a_sel;
  logic [7:0] b_sel;
  logic [3:0] a_ps, b_ps;
  logic [21:0] obs_a, obs_b;
  int tests = 0, fails = 0;
  int m_ph[2], m_addr[2], m_wait[2];
  bit m_pulse[2];

  router_fsm_nch dut_a (
    .clk(clk), .resetn(resetn), .packet_valid(pv), .data_in(din[1:0]), .fifo_full(full),
    .fifo_empty(emp[2:0]), .soft_reset(sr[2:0]), .parity_done(pd), .low_packet_valid(lpv),
    .write_enb_reg(a_we), .detect_add(a_da), .ld_state(a_ld), .laf_state(a_laf), .lfd_state(a_lfd),
    .full_state(a_full), .rst_int_reg(a_rst), .busy(a_busy), .drop_state(a_drop), .pkt_drop(a_pd),
    .sel(a_sel), .present_state(a_ps)
  );
  router_fsm_nch #(.NUM_CH(8), .ADDR_W(3), .WAIT_TIMEOUT(TO), .TO_W(6)) dut_b (
    .clk(clk), .resetn(resetn), .packet_valid(pv), .data_in(din), .fifo_full(full),
    .fifo_empty(emp), .soft_reset(sr), .parity_done(pd), .low_packet_valid(lpv),
    .write_enb_reg(b_we), .detect_add(b_da), .ld_state(b_ld), .laf_state(b_laf), .lfd_state(b_lfd),
    .full_state(b_full), .rst_int_reg(b_rst), .busy(b_busy), .drop_state(b_drop), .pkt_drop(b_pd),
    .sel(b_sel), .present_state(b_ps)
  );
  assign obs_a = {a_ps, 5'b0, a_sel, a_we, a_da, a_ld, a_laf, a_lfd, a_full, a_rst, a_busy, a_drop, a_pd};
  assign obs_b = {b_ps, b_sel, b_we, b_da, b_ld, b_laf, b_lfd, b_full, b_rst, b_busy, b_drop, b_pd};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = M_DA; m_addr[k] = 0; m_wait[k] = 0; m_pulse[k] = 1'b0;
    end
  endtask

  task automatic mstep(input int k, input int nch, input bit p, input int d, input bit f,
                       input logic [7:0] e, input logic [7:0] s, input bit pdi, input bit l);
    int cur, nxt;
    cur = m_ph[k];
    nxt = cur;
    if (cur != M_DA && cur != M_DRP && s[m_addr[k]]) nxt = M_DA;
    else case (cur)
      M_DA: if (p) begin
        m_addr[k] = d;
        m_wait[k] = 0;
        nxt = (d >= nch) ? M_DRP : e[d] ? M_LFD : M_WT;
      end
      M_WT: begin
        m_wait[k]++;
        if (e[m_addr[k]]) nxt = M_LFD;
        else if (TO != 0 && m_wait[k] >= TO) nxt = M_DRP;
      end
      M_LFD: nxt = M_LD;
      M_LD:  nxt = f ? M_FFS : (!p ? M_LP : M_LD);
      M_FFS: nxt = f ? M_FFS : M_LAF;
      M_LAF: nxt = pdi ? M_DA : (l ? M_LP : M_LD);
      M_LP:  nxt = M_CPE;
      M_CPE: nxt = f ? M_FFS : M_DA;
      M_DRP: nxt = p ? M_DRP : M_DA;
      default: nxt = M_DA;
    endcase
    m_pulse[k] = nxt == M_DRP && cur != M_DRP;
    m_ph[k] = nxt;
  endtask

  function automatic logic [21:0] expv(input int k);
    int p;
    logic [3:0] ps;
    logic [7:0] s;
    p = m_ph[k];
    case (p)
      M_WT:    ps = router_pkg::WAIT_TILL_EMPTY;
      M_LFD:   ps = router_pkg::LOAD_FIRST_DATA;
      M_LD:    ps = router_pkg::LOAD_DATA;
      M_FFS:   ps = router_pkg::FIFO_FULL_STATE;
      M_LAF:   ps = router_pkg::LOAD_AFTER_FULL;
      M_LP:    ps = router_pkg::LOAD_PARITY;
      M_CPE:   ps = router_pkg::CHECK_PARITY_ERROR;
      M_DRP:   ps = router_pkg::DROP_PACKET;
      default: ps = router_pkg::DECODE_ADDRESS;
    endcase
    s = (p == M_DA || p == M_DRP) ? 8'h00 : 8'(1 << m_addr[k]);
    return {ps, s, p inside {M_LD, M_LP, M_LAF}, p == M_DA, p == M_LD, p == M_LAF, p == M_LFD,
            p == M_FFS, p == M_CPE, !(p inside {M_DA, M_LD, M_DRP}), p == M_DRP, m_pulse[k]};
  endfunction

  task automatic check(input string tag);
    logic [21:0] ea, eb;
    ea = expv(0);
    eb = expv(1);
    tests += 2;
    assert (obs_a === ea) else begin fails++; $error("FAIL %s/ch3 obs=%h exp=%h", tag, obs_a, ea); end
    assert (obs_b === eb) else begin fails++; $error("FAIL %s/ch8 obs=%h exp=%h", tag, obs_b, eb); end
  endtask

  task automatic step(input bit p, input logic [2:0] d, input bit f, input logic [7:0] e,
                      input logic [7:0] s, input bit pdi, input bit l, input string tag);
    pv = p; din = d; full = f; emp = e; sr = s; pd = pdi; lpv = l;
    @(posedge clk);
    mstep(0, 3, p, int'(d[1:0]), f, e & 8'h07, s & 8'h07, pdi, l);
    mstep(1, 8, p, int'(d), f, e, s, pdi, l);
    @(negedge clk);
    check(tag);
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    #2;
    mreset();
    check(tag);
    @(negedge clk);
    check(tag);
    resetn = 1'b1;
  endtask

  initial begin
    bit rp, rf, rpd, rl;
    logic [2:0] rd;
    logic [7:0] re, rs;
    int mode;
    mode = 0;
    resetn = 1'b0; pv = 0; din = 0; full = 0; emp = 0; sr = 0; pd = 0; lpv = 0;
    @(negedge clk);
    mreset();
    check("reset");
    resetn = 1'b1;
    repeat (4) step(1, 3'd1, 0, 8'h02, 8'h00, 0, 0, "normal");
    repeat (3) step(0, 3'd1, 0, 8'h02, 8'h00, 0, 0, "normal_tail");
    repeat (3) step(1, 3'd3, 0, 8'hFF, 8'h00, 0, 0, "bad_addr");
    repeat (3) step(0, 3'd3, 0, 8'hFF, 8'h00, 0, 0, "bad_addr_tail");
    repeat (40) step(1, 3'd2, 0, 8'h00, 8'h00, 0, 0, "timeout");
    repeat (2) step(0, 3'd2, 0, 8'h00, 8'h00, 0, 0, "timeout_tail");
    repeat (31) step(1, 3'd2, 0, 8'h00, 8'h00, 0, 0, "late_empty");
    repeat (3) step(1, 3'd2, 0, 8'h04, 8'h00, 0, 0, "late_empty_hit");
    repeat (4) step(0, 3'd2, 0, 8'h04, 8'h00, 0, 0, "late_empty_tail");
    repeat (2) step(1, 3'd0, 0, 8'h01, 8'h00, 0, 0, "full_hdr");
    repeat (3) step(1, 3'd0, 1, 8'h01, 8'h00, 0, 0, "full_hold");
    repeat (4) step(0, 3'd0, 0, 8'h01, 8'h00, 0, 1, "full_release");
    repeat (2) step(1, 3'd1, 0, 8'h02, 8'h00, 0, 0, "srst_hdr");
    step(1, 3'd1, 0, 8'h02, 8'h02, 0, 0, "srst_sel");
    step(0, 3'd1, 0, 8'h02, 8'h00, 0, 0, "srst_idle");
    repeat (2) step(1, 3'd1, 0, 8'h02, 8'h00, 0, 0, "srst_hdr2");
    step(1, 3'd1, 0, 8'h02, 8'h04, 0, 0, "srst_other");
    repeat (3) step(0, 3'd1, 0, 8'h02, 8'h00, 0, 0, "srst_other_tail");
    repeat (3) step(1, 3'd7, 0, 8'h80, 8'h00, 0, 0, "ch7");
    do_reset("reset_mid_ld");
    repeat (2) step(0, 3'd0, 0, 8'h00, 8'h00, 0, 0, "after_reset");
    for (int i = 0; i < 3000; i++) begin
      if (i % 80 == 0) mode = $urandom_range(0, 2);
      rp  = $urandom_range(0, 9) < 7;
      rd  = 3'($urandom);
      rf  = $urandom_range(0, 3) == 0;
      re  = (mode == 1) ? 8'h00 : (mode == 2) ? 8'($urandom) : 8'($urandom) | 8'($urandom);
      rs  = ($urandom_range(0, 29) == 0) ? 8'($urandom) : 8'h00;
      rpd = $urandom_range(0, 3) == 0;
      rl  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 499) == 0) do_reset("rand_reset");
      step(rp, rd, rf, re, rs, rpd, rl, "random");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/router_fsm_nch.md
Name: router_fsm_nch

Overview:
- Parametrised control FSM for a 1xN packet router; the next generation of the 1x3 router controller.
- Sits between the input register/parity block and N output FIFOs; decodes the header address and sequences header, payload and parity loads.
- New over the 1x3 generation: configurable channel count, explicit handling of invalid addresses, and a wait-timeout that drops stalled packets.

Parameters:
- NUM_CH, 3, number of output channels/FIFOs (2..16)
- ADDR_W, 2, header address field width; must satisfy 2**ADDR_W >= NUM_CH
- WAIT_TIMEOUT, 32, max cycles spent in WAIT_TILL_EMPTY before drop; 0 disables the timeout
- TO_W, 6, timeout counter width; must hold WAIT_TIMEOUT

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- packet_valid  in  1  source asserts while a packet is on the bus
- data_in  in  ADDR_W  header address bits (byte[ADDR_W-1:0])
- fifo_full  in  1  full flag of the currently selected FIFO
- fifo_empty  in  NUM_CH  per-channel empty flags
- soft_reset  in  NUM_CH  per-channel soft reset from the output side
- parity_done  in  1  parity byte captured by the register block
- low_packet_valid  in  1  packet_valid fell while the FIFO was full
- write_enb_reg  out  1  write enable to the selected FIFO
- detect_add, ld_state, laf_state, lfd_state, full_state  out  1 each  state decodes
- rst_int_reg  out  1  reset the internal parity register
- busy  out  1  source must hold the bus
- drop_state  out  1  packet is being discarded
- pkt_drop  out  1  one-cycle pulse on entry to DROP_PACKET
- sel  out  NUM_CH  one-hot latched destination; all zero in DECODE_ADDRESS and DROP_PACKET
- present_state  out  4  debug view of the state register

Behaviour:
- States (4-bit encoding): DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, DROP_PACKET.
- Reset: state = DECODE_ADDRESS, addr_q = 0, timeout count = 0.
- Reset output values: detect_add = 1; sel = 0, pkt_drop = 0; all other outputs 0.
- addr_q is captured on the clock edge that leaves DECODE_ADDRESS with packet_valid = 1.
- DECODE_ADDRESS, with packet_valid = 1:
  - data_in >= NUM_CH -> DROP_PACKET
  - else fifo_empty[data_in] = 1 -> LOAD_FIRST_DATA
  - else -> WAIT_TILL_EMPTY
  - packet_valid = 0 -> stay.
- WAIT_TILL_EMPTY:
  - fifo_empty[addr_q] = 1 -> LOAD_FIRST_DATA
  - else count reaches WAIT_TIMEOUT-1 (WAIT_TIMEOUT != 0) -> DROP_PACKET
  - else stay.
  - Counter clears on every entry; emptiness wins over timeout when both occur in the same cycle.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
- LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !packet_valid -> LOAD_PARITY; else stay.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS
  - low_packet_valid -> LOAD_PARITY
  - else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- DROP_PACKET: stay while packet_valid; -> DECODE_ADDRESS when packet_valid = 0. No FIFO writes; busy = 0 so the source drains.
- Soft reset: soft_reset[addr_q] = 1 in any state except DECODE_ADDRESS and DROP_PACKET forces DECODE_ADDRESS next cycle, overriding all other transitions. Soft reset of a non-selected channel is ignored.
- Outputs are Moore decodes of present state (no added latency):
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
  - busy = every state except DECODE_ADDRESS, LOAD_DATA and DROP_PACKET
  - rst_int_reg = CHECK_PARITY_ERROR; lfd_state = LOAD_FIRST_DATA; ld_state = LOAD_DATA; laf_state = LOAD_AFTER_FULL; full_state = FIFO_FULL_STATE
  - pkt_drop is registered: high for the first cycle in DROP_PACKET only.
- Reset asserted mid-packet: immediate return to DECODE_ADDRESS with reset output values; no partial write pulse.

Decomposition:
- Shared package router_pkg: state enum/localparams (4-bit codes), NUM_CH and ADDR_W defaults, timeout width helper.
- One natural sub-module: router_wait_timer (loadable up-counter with clear, enable and terminal flag), instantiated once.

Test Plan:
- NUM_CH=3, data_in=1, fifo_empty=3'b010, packet_valid high 4 cycles -> states DA, LFD, LD x3, LP, CPE, DA; sel=3'b010; write_enb_reg high in LD and LP.
- NUM_CH=3, data_in=3 -> DROP_PACKET, pkt_drop single pulse, busy=0, sel=0, no write_enb_reg; back to DA one cycle after packet_valid falls.
- data_in=2, fifo_empty[2]=0 for 40 cycles, WAIT_TIMEOUT=32 -> DROP_PACKET on cycle 32 of waiting; repeat with fifo_empty[2] rising at cycle 31 -> LFD, no drop.
- fifo_full=1 in LD for 3 cycles, then 0 with low_packet_valid=1 -> FFS x3, LAF, LP, CPE; busy=1 throughout FFS.
- soft_reset=3'b010 while in LD to channel 1 -> DA next cycle; soft_reset=3'b100 in the same situation -> no effect.
- NUM_CH=8, ADDR_W=3, data_in=7, fifo_empty=8'h80 -> sel=8'h80, normal load; resetn low mid-LD -> DA immediately, detect_add=1.
